// File: rtl/maxpool_window_tracker.sv
// rtl/maxpool_window_tracker.sv - raster-order window tracker for non-overlapping max pooling
module maxpool_window_tracker #(
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100,
    parameter int POOL_K = 2,
    parameter int CNT_W  = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] col_o,
    output logic [CNT_W-1:0] row_o,
    output logic             row_sel_o,
    output logic             lb_wr_o,
    output logic             out_valid_o,
    output logic [CNT_W-1:0] out_col_o,
    output logic [CNT_W-1:0] out_row_o,
    output logic             frame_done_o
);

    localparam int PW      = $clog2(POOL_K);
    localparam int COL_LIM = (IMG_W / POOL_K) * POOL_K;
    localparam int ROW_LIM = (IMG_H / POOL_K) * POOL_K;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
    localparam logic [PW-1:0]    PH_LAST  = PW'(POOL_K - 1);
    // One extra bit so a limit equal to 2**CNT_W still compares correctly.
    localparam logic [CNT_W:0]   COL_LIM_C = (CNT_W+1)'(COL_LIM);
    localparam logic [CNT_W:0]   ROW_LIM_C = (CNT_W+1)'(ROW_LIM);

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [PW-1:0]    cph_q, cph_d;
    logic [PW-1:0]    rph_q, rph_d;
    logic [CNT_W-1:0] pcol_q, pcol_d;
    logic [CNT_W-1:0] prow_q, prow_d;
    logic [CNT_W-1:0] ocol_q, ocol_d;
    logic [CNT_W-1:0] orow_q, orow_d;
    logic             lb_wr_q, lb_wr_d;
    logic             ov_q, ov_d;
    logic             fd_q, fd_d;

    logic in_win;
    logic last_col, last_row, cph_last, rph_last;

    assign in_win   = ({1'b0, col_q} < COL_LIM_C) && ({1'b0, row_q} < ROW_LIM_C);
    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);
    assign cph_last = (cph_q == PH_LAST);
    assign rph_last = (rph_q == PH_LAST);

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        cph_d   = cph_q;
        rph_d   = rph_q;
        pcol_d  = pcol_q;
        prow_d  = prow_q;
        ocol_d  = ocol_q;
        orow_d  = orow_q;
        lb_wr_d = 1'b0;
        ov_d    = 1'b0;
        fd_d    = 1'b0;

        if (clr_i) begin
            col_d  = '0;
            row_d  = '0;
            cph_d  = '0;
            rph_d  = '0;
            pcol_d = '0;
            prow_d = '0;
            ocol_d = '0;
            orow_d = '0;
        end else if (en_i) begin
            // pcol/prow carry col/POOL_K and row/POOL_K so no divider is needed.
            if (in_win && cph_last) begin
                if (rph_last) begin
                    ov_d   = 1'b1;
                    ocol_d = pcol_q;
                    orow_d = prow_q;
                end else begin
                    lb_wr_d = 1'b1;
                end
            end

            if (last_col) begin
                col_d  = '0;
                cph_d  = '0;
                pcol_d = '0;
                if (last_row) begin
                    row_d  = '0;
                    rph_d  = '0;
                    prow_d = '0;
                    fd_d   = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                    if (rph_last) begin
                        rph_d  = '0;
                        prow_d = prow_q + 1'b1;
                    end else begin
                        rph_d = rph_q + 1'b1;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
                if (cph_last) begin
                    cph_d  = '0;
                    pcol_d = pcol_q + 1'b1;
                end else begin
                    cph_d = cph_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q   <= '0;
            row_q   <= '0;
            cph_q   <= '0;
            rph_q   <= '0;
            pcol_q  <= '0;
            prow_q  <= '0;
            ocol_q  <= '0;
            orow_q  <= '0;
            lb_wr_q <= 1'b0;
            ov_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            cph_q   <= cph_d;
            rph_q   <= rph_d;
            pcol_q  <= pcol_d;
            prow_q  <= prow_d;
            ocol_q  <= ocol_d;
            orow_q  <= orow_d;
            lb_wr_q <= lb_wr_d;
            ov_q    <= ov_d;
            fd_q    <= fd_d;
        end
    end

    assign col_o        = col_q;
    assign row_o        = row_q;
    assign row_sel_o    = (rph_q != '0);
    assign lb_wr_o      = lb_wr_q;
    assign out_valid_o  = ov_q;
    assign out_col_o    = ocol_q;
    assign out_row_o    = orow_q;
    assign frame_done_o = fd_q;

endmodule

// File: doc/maxpool_window_tracker.md
MAXPOOL_WINDOW_TRACKER -- requirements
Module: maxpool_window_tracker

Interface
REQ-001 Parameter IMG_W, default 100, input feature-map width in pixels (>= POOL_K).
REQ-002 Parameter IMG_H, default 100, input feature-map height in pixels (>= POOL_K).
REQ-003 Parameter POOL_K, default 2, square pooling window edge and stride (non-overlapping), legal 2..4.
REQ-004 Parameter CNT_W, default 7, width of column/row counters, >= clog2(max(IMG_W, IMG_H)).
REQ-005 Clk  input  1  rising-edge clock.
REQ-006 Rst  input  1  asynchronous active-low reset.
REQ-007 En  input  1  one input pixel accepted this cycle, raster order.
REQ-008 Clr  input  1  synchronous frame restart, returns all state to reset values.
REQ-009 Col  output  CNT_W  column index of the next pixel to be accepted.
REQ-010 Row  output  CNT_W  row index of the next pixel to be accepted.
REQ-011 Row_Sel  output  1  high while Row mod POOL_K != 0 (current row merges with stored partial maxima).
REQ-012 Lb_Wr  output  1  registered pulse: accepted pixel's partial max goes to line buffer (Row_Phase < POOL_K-1).
REQ-013 Out_Valid  output  1  registered pulse: accepted pixel completed a pooling window.
REQ-014 Out_Col, Out_Row  output  CNT_W each  output-map coordinates qualified by Out_Valid.
REQ-015 Frame_Done  output  1  registered pulse on the last pixel of a frame.

Function
REQ-016 Internal Col_Phase/Row_Phase counters (0..POOL_K-1) shall track Col mod POOL_K and Row mod POOL_K without a divider.
REQ-017 On En: Col +1; at Col = IMG_W-1, Col -> 0, Row +1, Col_Phase -> 0; Row_Phase advances only on row wrap.
REQ-018 At Col = IMG_W-1 and Row = IMG_H-1 with En: Col, Row and both phases -> 0; Frame_Done = 1 next cycle.
REQ-019 En low: all counters hold; Lb_Wr, Out_Valid, Frame_Done = 0 next cycle.
REQ-020 Clr high shall take priority over En: counters, phases and outputs -> 0 next cycle; the pixel presented with Clr is discarded.
REQ-021 Pixel counts as in-window only if Col < (IMG_W/POOL_K)*POOL_K and Row < (IMG_H/POOL_K)*POOL_K (integer division); trailing columns/rows are dropped.
REQ-022 Out_Valid shall be 1 exactly one cycle after an accepted in-window pixel with Col_Phase = Row_Phase = POOL_K-1.
REQ-023 Out_Col/Out_Row shall equal Col/POOL_K and Row/POOL_K of that pixel, held stable until the next Out_Valid.
REQ-024 Lb_Wr shall be 1 one cycle after an accepted in-window pixel with Col_Phase = POOL_K-1 and Row_Phase < POOL_K-1.
REQ-025 Row_Sel shall be combinational from registered Row_Phase (for POOL_K = 2 it equals Row[0]).
REQ-026 Out_Valid and Frame_Done may assert in the same cycle; no other mutual exclusion is imposed.
REQ-027 Latency from En to any pulse output shall be exactly 1 cycle; back-to-back En shall be sustained with no bubbles.

Reset
REQ-028 Rst low shall asynchronously force Col, Row, phases, Out_Col, Out_Row, Lb_Wr, Out_Valid, Frame_Done to 0 and hence Row_Sel to 0.
REQ-029 Rst deassertion mid-frame shall restart counting at pixel (0,0); no partial window survives reset.

Verification
REQ-030 IMG_W=IMG_H=4, POOL_K=2, 16 consecutive En -> Out_Valid on pixels 5,7,13,15 (0-based) with (Out_Row,Out_Col) = (0,0),(0,1),(1,0),(1,1); Frame_Done with pixel 15.
REQ-031 IMG_W=5, IMG_H=5, POOL_K=2, full frame -> exactly 4 Out_Valid; none for Col=4 or Row=4; Frame_Done after 25th pixel.
REQ-032 IMG_W=IMG_H=6, POOL_K=3, En toggling 1/0 -> 4 Out_Valid; counters hold during En=0; Lb_Wr on Col_Phase=2 in rows 0,1,3,4 only.
REQ-033 Default parameters, 250 pixels then Clr with En=1 -> Col=Row=0 next cycle, no Out_Valid from the Clr pixel, next pixel counted as (0,0).
REQ-034 Rst pulsed low asynchronously mid-row (Col=37) -> all outputs 0 immediately; after release, first Out_Valid at pixel index IMG_W+1.
REQ-035 Default parameters, 10000 En -> 2500 Out_Valid, 1 Frame_Done, Row_Sel equals Row[0] every cycle.
